// File: rtl/dvsd_mac_pkg.sv
// Shared definitions for the 8x8 multiply-accumulate block: frame limits,
// default widths and the controller state encoding.
package dvsd_mac_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 9;
    localparam int MAX_PAIRS = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dvsd_8216m1.sv
// Unsigned 8x8 Dadda multiplier: partial-product columns are compressed to
// heights 6, 4, 3, 2 with full/half adders, then summed by one final adder.
module dvsd_8216m1 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    logic        cur  [16][8];
    logic        nxt  [16][8];
    int          ncur [16];
    int          nnxt [16];
    logic [15:0] row0;
    logic [15:0] row1;

    function automatic int dadda_height(input int stage);
        return (stage == 0) ? 6 : (stage == 1) ? 4 : (stage == 2) ? 3 : 2;
    endfunction

    always_comb begin
        int   cin;
        int   excess;
        int   nfa;
        int   nha;
        int   src;
        int   d;
        logic x;
        logic y;
        logic z;
        cin    = 0;
        excess = 0;
        nfa    = 0;
        nha    = 0;
        src    = 0;
        d      = 0;
        x      = 1'b0;
        y      = 1'b0;
        z      = 1'b0;
        cur    = '{default: '{default: 1'b0}};
        nxt    = '{default: '{default: 1'b0}};
        ncur   = '{default: 0};
        nnxt   = '{default: 0};
        row0   = '0;
        row1   = '0;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cur[4'(i + j)][3'(ncur[i + j])] = a_i[3'(i)] & b_i[3'(j)];
                ncur[i + j] = ncur[i + j] + 1;
            end
        end

        for (int s = 0; s < 4; s++) begin
            d    = dadda_height(s);
            nxt  = '{default: '{default: 1'b0}};
            nnxt = '{default: 0};
            cin  = 0;
            for (int c = 0; c < 16; c++) begin
                // Reduce just enough that this column plus incoming carries meets d.
                excess = ncur[c] + cin - d;
                nfa    = (excess > 0) ? excess / 2 : 0;
                nha    = (excess > 0) ? excess % 2 : 0;
                src    = 0;
                for (int f = 0; f < 3; f++) begin
                    if (f < nfa) begin
                        x = cur[4'(c)][3'(src)];
                        y = cur[4'(c)][3'(src + 1)];
                        z = cur[4'(c)][3'(src + 2)];
                        nxt[4'(c)][3'(nnxt[c])] = x ^ y ^ z;
                        nnxt[c] = nnxt[c] + 1;
                        if (c < 15) begin
                            nxt[4'(c + 1)][3'(nnxt[c + 1])] = (x & y) | (x & z) | (y & z);
                            nnxt[c + 1] = nnxt[c + 1] + 1;
                        end
                        src = src + 3;
                    end
                end
                if (nha > 0) begin
                    x = cur[4'(c)][3'(src)];
                    y = cur[4'(c)][3'(src + 1)];
                    nxt[4'(c)][3'(nnxt[c])] = x ^ y;
                    nnxt[c] = nnxt[c] + 1;
                    if (c < 15) begin
                        nxt[4'(c + 1)][3'(nnxt[c + 1])] = x & y;
                        nnxt[c + 1] = nnxt[c + 1] + 1;
                    end
                    src = src + 2;
                end
                for (int r = 0; r < 8; r++) begin
                    if (r >= src && r < ncur[c]) begin
                        nxt[4'(c)][3'(nnxt[c])] = cur[4'(c)][3'(r)];
                        nnxt[c] = nnxt[c] + 1;
                    end
                end
                cin = nfa + nha;
            end
            cur  = nxt;
            ncur = nnxt;
        end

        for (int c = 0; c < 16; c++) begin
            row0[4'(c)] = cur[4'(c)][0];
            row1[4'(c)] = cur[4'(c)][1];
        end
    end

    assign p_o = row0 + row1;

endmodule

// File: rtl/dvsd_8216mac.sv
// Framed unsigned 8x8 multiply-accumulate: operand, product and accumulate
// stages, with a result held until the consumer handshakes it away.
//
// state | meaning
// IDLE  | no pair of the current frame accepted yet
// RUN   | frame open, accepting pairs
// FLUSH | last pair taken, draining the pipeline into the running sum
// DONE  | result presented (out_valid) until out_ready
module dvsd_8216mac
    import dvsd_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    state_e           state_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic             v1_q;
    logic             last1_q;
    logic             trunc1_q;
    logic [15:0]      prod;
    logic [15:0]      p_q;
    logic             v2_q;
    logic             last2_q;
    logic             trunc2_q;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] sum_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             trunc_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_trunc_q;
    logic             accept;
    logic             at_limit;
    logic             last_d;

    assign in_ready = !rst && (state_q == ST_IDLE || state_q == ST_RUN);
    assign accept   = in_valid && in_ready;
    // The pair that would make the frame full closes it even without in_last.
    assign at_limit = (cnt_q == CNT_W'(MAX_PAIRS - 1));
    assign last_d   = in_last || at_limit;
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign sum_d    = sum_q + ACC_W'(p_q);

    dvsd_8216m1 u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                last1_q  <= last_d;
                trunc1_q <= at_limit && !in_last;
                cnt_q    <= cnt_d;
            end

            v2_q <= v1_q;
            if (v1_q) begin
                p_q      <= prod;
                last2_q  <= last1_q;
                trunc2_q <= trunc1_q;
            end

            if (v2_q) begin
                sum_q <= sum_d;
                if (last2_q) begin
                    trunc_q <= trunc2_q;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= last_d ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && last_d) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (v2_q && last2_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        acc_q       <= sum_q;
                        out_count_q <= cnt_q;
                        out_trunc_q <= trunc_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        sum_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_dvsd_8216mac.sv
// Scoreboard bench for dvsd_8216mac: a frame-level arithmetic model queues the
// expected results, a negedge monitor checks them at each output handshake.
module tb_dvsd_8216mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] acc;
    logic [8:0]  out_count;
    logic        out_trunc;

    logic [7:0]  ma;
    logic [7:0]  mb;
    logic [15:0] mp;

    always #5 clk = ~clk;

    dvsd_8216mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    dvsd_8216m1 u_mul_sweep (
        .a_i (ma),
        .b_i (mb),
        .p_o (mp)
    );

    typedef struct {
        logic [23:0] acc;
        int          cnt;
        logic        trunc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] mdl_sum;
    int          mdl_cnt;
    bit          rand_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Frame model: a frame ends on in_last or on its 256th pair.
    task automatic model_accept(input logic [7:0] av, input logic [7:0] bv, input logic lv);
        exp_t e;
        mdl_sum = mdl_sum + 24'(int'(av) * int'(bv));
        mdl_cnt++;
        if (lv || mdl_cnt == 256) begin
            e.acc   = mdl_sum;
            e.cnt   = mdl_cnt;
            e.trunc = (mdl_cnt == 256) && !lv;
            sb.push_back(e);
            mdl_sum = '0;
            mdl_cnt = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send_pair(input logic [7:0] av, input logic [7:0] bv, input logic lv);
        int t;
        t        = 0;
        a        = av;
        b        = bv;
        in_last  = lv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        model_accept(av, bv, lv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || !in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d in_ready=%0b, expected 0 and 1", sb.size(), in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: acc=0x%0h count=%0d, expected no result", acc, out_count);
                end else begin
                    e = sb.pop_front();
                    chk("res_acc", 32'(acc), 32'(e.acc));
                    chk("res_count", 32'(out_count), 32'(e.cnt));
                    chk("res_trunc", 32'(out_trunc), 32'(e.trunc));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int          t;
        int          len;
        int          prodv;
        logic [7:0]  ra;
        logic [7:0]  rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rand_rdy  = 1'b0;
        mdl_sum   = '0;
        mdl_cnt   = 0;
        ma        = '0;
        mb        = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_trunc", 32'(out_trunc), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single max pair and its latency
        send_pair(8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("lat_k2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_k3_valid", 32'(out_valid), 32'd1);
        wait_drain();

        // Three-pair frame with an input gap
        send_pair(8'd3, 8'd4, 1'b0);
        send_pair(8'd5, 8'd6, 1'b0);
        #20;
        send_pair(8'd7, 8'd8, 1'b1);
        wait_drain();

        // Back-pressure in DONE
        out_ready = 1'b0;
        send_pair(8'd10, 8'd20, 1'b1);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_rise", 32'(out_valid), 32'd1);
        repeat (5) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_acc", 32'(acc), 32'd200);
            chk("bp_hold_count", 32'(out_count), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_pending_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("hs_after_valid", 32'(out_valid), 32'd0);
        chk("hs_after_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Length limit: 256 pairs without in_last, then a one-pair frame
        for (int i = 0; i < 256; i++) send_pair(8'hFF, 8'hFF, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("limit_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        send_pair(8'd1, 8'd2, 1'b1);
        wait_drain();

        // in_last exactly on the 256th pair is not a truncation
        for (int i = 0; i < 256; i++) send_pair(8'(i), 8'(255 - i), i == 255);
        wait_drain();

        // Reset mid-frame discards in-flight pairs
        send_pair(8'd9, 8'd9, 1'b0);
        send_pair(8'd4, 8'd4, 1'b0);
        rst     = 1'b1;
        mdl_sum = '0;
        mdl_cnt = 0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_acc", 32'(acc), 32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
        chk("midrst_trunc", 32'(out_trunc), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send_pair(8'd2, 8'd3, 1'b1);
        wait_drain();

        // Randomised frames, gaps and consumer stalls
        rand_rdy = 1'b1;
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                send_pair(ra, rb, i == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    t = $urandom_range(1, 3);
                    #(10 * t);
                end
            end
        end
        @(posedge clk);
        #2;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Every operand pair through the product stage
        for (int i = 0; i < 65536; i++) begin
            ma    = 8'(i / 256);
            mb    = 8'(i % 256);
            prodv = (i / 256) * (i % 256);
            #1;
            chk("mul_product", 32'(mp), 32'(prodv));
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dvsd_8216mac.md
DVSD_8216MAC -- requirements
Module: dvsd_8216mac

Interface
Parameters:
REQ-001 SHALL have parameter ACC_W, default 24: accumulator and result width; no overflow for a 256-pair frame of 255x255.
REQ-002 SHALL have parameter CNT_W, default 9: pair-count width; 256 is the maximum frame length.

Ports:
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  operand pair a/b/in_last present.
REQ-006 SHALL have port in_ready  out  1  block accepts the pair this cycle.
REQ-007 SHALL have port a  in  8  unsigned multiplicand.
REQ-008 SHALL have port b  in  8  unsigned multiplier.
REQ-009 SHALL have port in_last  in  1  pair is the final one of the frame.
REQ-010 SHALL have port out_valid  out  1  result is held on acc/out_count/out_trunc.
REQ-011 SHALL have port out_ready  in  1  consumer takes the result.
REQ-012 SHALL have port acc  out  ACC_W  sum of a*b over the frame.
REQ-013 SHALL have port out_count  out  CNT_W  number of pairs in the frame (1..256).
REQ-014 SHALL have port out_trunc  out  1  frame closed by the length limit, not by in_last.

Function
REQ-015 SHALL accept a pair on any edge where in_valid && in_ready; gaps in in_valid SHALL NOT affect the result.
REQ-016 SHALL run a 3-stage pipeline:
- operand register (a_q, b_q, last_q, v1);
- product register p_q = a_q*b_q, exact unsigned 16-bit;
- accumulate/result register.
REQ-017 SHALL define latency as follows: if the last pair is accepted on edge k, out_valid SHALL rise after edge k+3.
REQ-018 SHALL have FSM states IDLE, RUN, FLUSH, DONE; in_ready = 1 only in IDLE or RUN and rst low.
REQ-019 SHALL take these FSM transitions:
- IDLE->RUN on acceptance without last;
- IDLE->FLUSH or RUN->FLUSH on acceptance with last (or forced last);
- FLUSH->DONE when the last product is accumulated;
- DONE->IDLE on out_valid && out_ready.
REQ-020 SHALL load the first product of a frame into the running sum (starting from 0) and add every later product to it, with ACC_W-bit unsigned arithmetic.
REQ-021 SHALL treat the 256th accepted pair of a frame as last regardless of in_last, and set out_trunc=1; out_trunc=0 otherwise.
REQ-022 SHALL NOT set out_trunc when in_last arrives on the 256th pair itself.
REQ-023 SHALL hold acc, out_count and out_trunc stable while out_valid && !out_ready.
REQ-024 SHALL deassert out_valid on the edge after the handshake, clear the running sum and count, and return in_ready=1 in the next cycle.
REQ-025 SHALL NOT let a frame's data affect a later frame.

Reset
REQ-026 SHALL, on an edge with rst=1, enter IDLE and clear v1, v2, the running sum and the count.
REQ-027 SHALL, on an edge with rst=1, drive out_valid=0, acc=0, out_count=0 and out_trunc=0.
REQ-028 SHALL drive in_ready=0 combinationally while rst=1.
REQ-029 SHALL discard in-flight pairs when reset is asserted mid-frame or in DONE; no partial result is ever presented.

Structure
REQ-030 SHALL place the state encoding (IDLE=0, RUN=1, FLUSH=2, DONE=3), ACC_W default and CNT_W default in shared package dvsd_mac_pkg.
REQ-031 SHALL form the product stage from exactly one instance of dvsd_8216m1 (8x8 Dadda multiplier), fed by a_q/b_q, with its 16 outputs registered into p_q.
REQ-032 SHALL place all control and accumulation in plain synchronous RTL in dvsd_8216mac; no gate-level primitives at this level.

Verification
REQ-033 SHALL cover single pair a=0xFF, b=0xFF, in_last=1 -> acc=0x00FE01, out_count=1, out_trunc=0, out_valid 3 edges after accept.
REQ-034 SHALL cover frame (3,4),(5,6),(7,8,last), with a 2-cycle in_valid gap mid-frame -> acc=98 (0x62), out_count=3.
REQ-035 SHALL cover 256 pairs of 0xFF x 0xFF with in_last=0 -> acc=0xFE0100, out_count=256, out_trunc=1, in_ready=0 from the 256th accept until the handshake.
REQ-036 SHALL cover out_ready held low 5 cycles in DONE -> out_valid/acc/out_count unchanged, in_ready=0; raise out_ready -> out_valid=0 and in_ready=1 one cycle later.
REQ-037 SHALL cover rst pulsed after 2 accepted pairs -> all outputs 0, no out_valid; then frame (2,3,last) -> acc=6, out_count=1.
REQ-038 SHALL cover exhaustive single-pair frames over all 65536 (a,b) -> acc equals the behavioural a*b every time, every product bit checked.
